// File: rtl/capture_fifo.sv
// Trigger-aware capture buffer: rolling pre-trigger window, post-trigger fill, then drain.
// Define CAPTURE_FIFO_TRIG_MARK_EN to store and present a first-post-trigger marker bit.
module capture_fifo #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int CNT_W     = 8,
   parameter int CNT_SHIFT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              set_counters_i,
   input  logic [CNT_W-1:0]  pre_count_i,
   input  logic [CNT_W-1:0]  post_count_i,
   input  logic              arm_i,
   input  logic              trigger_i,
   input  logic              data_valid_i,
   input  logic [DATA_W-1:0] data_in_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] data_out_o,
   output logic              out_valid_o,
   output logic              trig_mark_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic [1:0]        state_o,
   output logic              done_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int LW    = ADDR_W + 1;
   localparam int PW    = CNT_W + CNT_SHIFT;
`ifdef CAPTURE_FIFO_TRIG_MARK_EN
   localparam int MW    = DATA_W + 1;
`else
   localparam int MW    = DATA_W;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_POST = 2'd2,
      S_DONE = 2'd3
   } state_e;

   logic [MW-1:0]     mem [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [LW-1:0]     pre_tgt_q, pre_tgt_d;
   logic [PW-1:0]     post_tgt_q, post_tgt_d;
   logic [PW-1:0]     post_cnt_q, post_cnt_d;
   logic [DATA_W-1:0] data_out_q;
   logic              out_valid_q;

   logic              we;
   logic              rd_acc;
   logic [LW-1:0]     cap;
   logic [MW-1:0]     wdata;
   logic [MW-1:0]     rdata;
   logic [31:0]       pre_sc;

   assign pre_sc = 32'(pre_count_i) << CNT_SHIFT;
   assign rdata  = mem[rd_ptr_q];

`ifdef CAPTURE_FIFO_TRIG_MARK_EN
   // Marker is set on the trigger-cycle write or the first write after it
   assign wdata = {(state_q == S_PRE && trigger_i) ||
                   (state_q == S_POST && post_cnt_q == '0), data_in_i};
`else
   assign wdata = data_in_i;
`endif

   assign rd_acc = rd_en_i && !empty_o && !clear_i && !arm_i &&
                   (state_q == S_IDLE || state_q == S_DONE);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      pre_tgt_d  = pre_tgt_q;
      post_tgt_d = post_tgt_q;
      post_cnt_d = post_cnt_q;
      we         = 1'b0;
      cap        = LW'(DEPTH);
      if (clear_i) begin
         state_d    = S_IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         post_cnt_d = '0;
      end else if (arm_i && (state_q == S_IDLE || state_q == S_DONE)) begin
         state_d    = S_PRE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         post_cnt_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (set_counters_i) begin
                  pre_tgt_d  = (pre_sc >= 32'(DEPTH)) ? LW'(DEPTH) : pre_sc[LW-1:0];
                  post_tgt_d = PW'(post_count_i) << CNT_SHIFT;
               end
            end
            S_PRE: begin
               if (trigger_i) begin
                  if (post_tgt_q == '0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_POST;
                     we      = data_valid_i;
                  end
               end else if (data_valid_i && pre_tgt_q != '0) begin
                  we  = 1'b1;
                  cap = pre_tgt_q;
               end
            end
            S_POST: we = data_valid_i;
            default: ;
         endcase
         // A write into a buffer at its cap overwrites the oldest sample
         if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (level_q == cap) rd_ptr_d = rd_ptr_q + 1'b1;
            else                level_d  = level_q + 1'b1;
            if (state_d == S_POST) begin
               post_cnt_d = post_cnt_q + 1'b1;
               if (post_cnt_d == post_tgt_q || level_d == LW'(DEPTH))
                  state_d = S_DONE;
            end
         end
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         level_d  = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pre_tgt_q   <= '0;
         post_tgt_q  <= '0;
         post_cnt_q  <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pre_tgt_q   <= pre_tgt_d;
         post_tgt_q  <= post_tgt_d;
         post_cnt_q  <= post_cnt_d;
         out_valid_q <= rd_acc;
         if (clear_i)     data_out_q <= '0;
         else if (rd_acc) data_out_q <= rdata[DATA_W-1:0];
      end
   end

`ifdef CAPTURE_FIFO_TRIG_MARK_EN
   logic trig_mark_q;

   always_ff @(posedge clk) begin
      if (reset || clear_i) trig_mark_q <= 1'b0;
      else if (rd_acc)      trig_mark_q <= rdata[DATA_W];
   end

   assign trig_mark_o = trig_mark_q;
`else
   assign trig_mark_o = 1'b0;
`endif

   assign data_out_o  = data_out_q;
   assign out_valid_o = out_valid_q;
   assign level_o     = level_q;
   assign full_o      = (level_q == LW'(DEPTH));
   assign empty_o     = (level_q == '0);
   assign state_o     = state_q;
   assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_capture_fifo.sv
// Directed bench for capture_fifo at DATA_W=8, ADDR_W=4.
// Trig-mark expectations follow CAPTURE_FIFO_TRIG_MARK_EN.
module tb_capture_fifo;

   logic       clk = 1'b0;
   logic       reset, clear, set_cnt, arm, trig, dv, rd_en;
   logic [7:0] pre_c, post_c, din;
   logic [7:0] dout;
   logic       ov, tmark, full, empty, done;
   logic [4:0] level;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;
   int pulses;

   capture_fifo #(
      .DATA_W(8), .ADDR_W(4), .CNT_W(8), .CNT_SHIFT(2)
   ) dut (
      .clk(clk), .reset(reset), .clear_i(clear),
      .set_counters_i(set_cnt), .pre_count_i(pre_c),
      .post_count_i(post_c), .arm_i(arm), .trigger_i(trig),
      .data_valid_i(dv), .data_in_i(din), .rd_en_i(rd_en),
      .data_out_o(dout), .out_valid_o(ov), .trig_mark_o(tmark),
      .full_o(full), .empty_o(empty), .level_o(level),
      .state_o(state), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      clear = 0; set_cnt = 0; arm = 0; trig = 0;
      dv = 0; rd_en = 0; din = 8'h00;
   endtask

   task automatic setup(input logic [7:0] p, input logic [7:0] q);
      idle_in();
      clear = 1; tick(); clear = 0;
      set_cnt = 1; pre_c = p; post_c = q; tick(); set_cnt = 0;
      arm = 1; tick(); arm = 0;
   endtask

   task automatic push(input logic [7:0] v);
      dv = 1; din = v; tick(); dv = 0;
   endtask

   function automatic logic mark_exp(input logic [7:0] v);
`ifdef CAPTURE_FIFO_TRIG_MARK_EN
      return v == 8'h0A;
`else
      return 1'b0 && v[0];
`endif
   endfunction

   initial begin
      pre_c = 0; post_c = 0;
      idle_in();
      reset = 1; tick(); tick(); reset = 0;
      chk("rst_state", 32'(state), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_level", 32'(level), 0);
      chk("rst_ov", 32'(ov), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_dout", 32'(dout), 0);

      // pre 4, post 4
      setup(8'd1, 8'd1);
      chk("arm_state", 32'(state), 1);
      for (int i = 0; i < 10; i++) push(8'(i));
      chk("pre_level", 32'(level), 4);
      trig = 1; dv = 1; din = 8'h0A; tick(); trig = 0; dv = 0;
      chk("trig_state", 32'(state), 2);
      chk("trig_level", 32'(level), 5);
      for (int i = 11; i < 14; i++) push(8'(i));
      chk("post_state", 32'(state), 3);
      chk("post_done", 32'(done), 1);
      chk("post_level", 32'(level), 8);
      rd_en = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rd_ov", 32'(ov), 1);
         chk("rd_data", 32'(dout), 32'(6 + i));
         chk("rd_mark", 32'(tmark), 32'(mark_exp(8'(6 + i))));
      end
      rd_en = 0; tick();
      chk("rd_ov_end", 32'(ov), 0);
      chk("rd_empty", 32'(empty), 1);

      // pre 16 (clamped), post 8: full ends capture
      setup(8'd4, 8'd2);
      for (int i = 0; i < 20; i++) push(8'(8'h20 + i));
      chk("win_level", 32'(level), 16);
      chk("win_full", 32'(full), 1);
      trig = 1; tick(); trig = 0;
      chk("win_trig", 32'(state), 2);
      push(8'h50);
      chk("win_done", 32'(state), 3);
      chk("win_lvl2", 32'(level), 16);
      rd_en = 1; tick(); rd_en = 0;
      chk("win_oldest", 32'(dout), 32'h25);

      // post 0: trigger goes straight to DONE, sample dropped
      setup(8'd1, 8'd0);
      for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
      trig = 1; dv = 1; din = 8'h99; tick(); trig = 0; dv = 0;
      chk("p0_state", 32'(state), 3);
      chk("p0_level", 32'(level), 3);

      // clear mid-POSTTRIG, re-arm keeps targets
      setup(8'd1, 8'd4);
      for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
      trig = 1; dv = 1; din = 8'h44; tick(); trig = 0; dv = 0;
      push(8'h45);
      chk("clr_pre_st", 32'(state), 2);
      chk("clr_pre_lv", 32'(level), 6);
      clear = 1; tick(); clear = 0;
      chk("clr_state", 32'(state), 0);
      chk("clr_empty", 32'(empty), 1);
      chk("clr_level", 32'(level), 0);
      arm = 1; tick(); arm = 0;
      for (int i = 0; i < 6; i++) push(8'(8'h70 + i));
      chk("rearm_st", 32'(state), 1);
      chk("rearm_lv", 32'(level), 4);

      // DONE with two samples, reads held past empty
      setup(8'd1, 8'd0);
      push(8'h81); push(8'h82);
      trig = 1; tick(); trig = 0;
      chk("d2_state", 32'(state), 3);
      trig = 1; dv = 1; din = 8'hEE; tick(); trig = 0; dv = 0;
      chk("d2_ign_lv", 32'(level), 2);
      chk("d2_ign_st", 32'(state), 3);
      pulses = 0;
      rd_en = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ov) begin
            chk("d2_data", 32'(dout), 32'(8'h81 + pulses));
            pulses++;
         end
      end
      rd_en = 0; tick();
      chk("d2_pulses", 32'(pulses), 2);
      chk("d2_empty", 32'(empty), 1);
      chk("d2_level", 32'(level), 0);
      chk("d2_state2", 32'(state), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
